// File: rtl/burst_rom.sv
// Line-fetch ROM: one request returns a BURST-word line, critical word first,
// wrapping inside the aligned line. Outputs are registered; flush aborts a burst.
module burst_rom #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned BURST      = 4,
    parameter string       INIT_FILE  = ""
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  flush,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  last
);

    localparam int unsigned OFF_WIDTH = $clog2(BURST);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [OFF_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;

    logic [OFF_WIDTH-1:0]  rd_off;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  burst_end;

    // Offset arithmetic is OFF_WIDTH wide so the line index never changes.
    assign rd_off    = base_q[OFF_WIDTH-1:0] + cnt_q;
    assign rd_addr   = {base_q[ADDR_WIDTH-1:OFF_WIDTH], rd_off};
    assign burst_end = (cnt_q == OFF_WIDTH'(BURST - 1));

    assign rd_word = DATA_WIDTH'(rd_addr);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req && !flush) begin
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (flush || burst_end) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        base_d  = base_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req && !flush) begin
                    base_d = address;
                    cnt_d  = '0;
                end
            end
            StBurst: begin
                if (!flush) begin
                    data_d  = rd_word;
                    valid_d = 1'b1;
                    last_d  = burst_end;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            base_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign busy  = (state_q == StBurst);
    assign data  = data_q;
    assign valid = valid_q;
    assign last  = last_q;

endmodule

// File: tb/tb_burst_rom.sv
// Scoreboard bench for burst_rom: stimulus pushes expected {last, data}, a negedge
// monitor pops and compares whenever valid is high.
module tb_burst_rom;

    logic        clock = 1'b0;
    logic        reset;
    logic        req;
    logic [5:0]  address;
    logic        flush;
    logic        busy;
    logic [63:0] data;
    logic        valid;
    logic        last;

    int errors = 0;
    int checks = 0;
    int pushed = 0;
    int popped = 0;

    logic [64:0] exp_q[$];

    burst_rom dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .address (address),
        .flush   (flush),
        .busy    (busy),
        .data    (data),
        .valid   (valid),
        .last    (last)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_word(input int val, input bit is_last);
        exp_q.push_back({is_last, 64'(val)});
        pushed++;
    endtask

    // Raise req so the next rising edge accepts it; returns 1ns after that edge.
    task automatic start(input int addr);
        req     = 1'b1;
        address = 6'(addr);
        @(posedge clock);
        #1 req = 1'b0;
        chk("busy_after_accept", 64'(busy), 64'd1);
    endtask

    task automatic burst4(input string tag, input int a, input int w0, input int w1,
                          input int w2, input int w3);
        expect_word(w0, 0);
        expect_word(w1, 0);
        expect_word(w2, 0);
        expect_word(w3, 1);
        start(a);
        repeat (3) @(posedge clock);
        #1 chk({tag, "_busy_mid"}, 64'(busy), 64'd1);
        @(posedge clock);
        #1 chk({tag, "_busy_end"}, 64'(busy), 64'd0);
        @(posedge clock);
        #1 chk({tag, "_valid_drop"}, 64'(valid), 64'd0);
        chk({tag, "_data_hold"}, data, 64'(w3));
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (last && !valid) begin
                checks++;
                errors++;
                $display("FAIL last_without_valid: got last=1 valid=0 expected last=0");
            end
            if (valid) begin
                logic [64:0] e;
                checks++;
                popped++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got data=%0h last=%0b expected no word",
                             data, last);
                end else begin
                    e = exp_q.pop_front();
                    if ({last, data} !== e) begin
                        errors++;
                        $display("FAIL word: got data=%0h last=%0b expected data=%0h last=%0b",
                                 data, last, e[63:0], e[64]);
                    end
                end
            end
        end
    end

    initial begin
        reset   = 1'b1;
        req     = 1'b0;
        address = '0;
        flush   = 1'b0;
        #2;
        chk("reset_data", data, 64'd0);
        chk("reset_flags", {61'd0, valid, last, busy}, 64'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        burst4("aligned8", 8, 8, 9, 10, 11);
        burst4("wrap14", 14, 14, 15, 12, 13);
        burst4("wrap63", 63, 63, 60, 61, 62);

        // Second req during a burst must be dropped, not queued.
        expect_word(8, 0);
        expect_word(9, 0);
        expect_word(10, 0);
        expect_word(11, 1);
        start(8);
        req     = 1'b1;
        address = 6'd20;
        repeat (2) @(posedge clock);
        #1 req = 1'b0;
        repeat (2) @(posedge clock);
        #1 chk("busyreq_end", 64'(busy), 64'd0);
        repeat (3) begin
            @(posedge clock);
            #1 chk("busyreq_no_second", {62'd0, busy, valid}, 64'd0);
        end

        // Flush after two words.
        expect_word(4, 0);
        expect_word(5, 0);
        start(4);
        repeat (2) @(posedge clock);
        #1 flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        chk("flush_idle", {62'd0, busy, valid}, 64'd0);
        chk("flush_data_hold", data, 64'd5);
        burst4("after_flush0", 0, 0, 1, 2, 3);

        // Async reset mid-burst, after the first word has been sampled.
        expect_word(16, 0);
        start(16);
        @(posedge clock);
        @(negedge clock);
        #1 reset = 1'b1;
        #1 chk("midreset_data", data, 64'd0);
        chk("midreset_flags", {61'd0, valid, last, busy}, 64'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        burst4("after_reset32", 32, 32, 33, 34, 35);

        repeat (3) @(posedge clock);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("word_count", 64'(popped), 64'(pushed));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
